// File: rtl/seq_frame_pkg.sv
// Shared types and defaults for the 011XXX110 serial frame transmitter.
package seq_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam logic [2:0] SEQ_HEADER    = 3'b011;
  localparam logic [2:0] SEQ_TRAILER   = 3'b110;
  localparam int         SEQ_PAYLOAD_W = 3;

  function automatic int frame_len(input int hdr_w, input int payload_w);
    return 2 * hdr_w + payload_w;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, serial-out shift register; bit_out is registered and
// falls back to IDLE_BIT whenever the register is neither loaded nor shifted.
module seq_piso
  #(parameter int   WIDTH    = 9,
    parameter logic IDLE_BIT = 1'b0)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out
  );

  // The MSB goes straight to bit_out on load, so only WIDTH-1 bits are held.
  logic [WIDTH-2:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_out <= IDLE_BIT;
    end else if (load) begin
      bit_out <= load_data[WIDTH-1];
      shreg   <= load_data[WIDTH-2:0];
    end else if (shift) begin
      bit_out <= shreg[WIDTH-2];
      shreg   <= shreg << 1;
    end else begin
      bit_out <= IDLE_BIT;
    end
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a payload on valid/ready and emits
// HEADER, payload, TRAILER MSB-first, one bit per clock.
module seq_frame_tx
  import seq_frame_pkg::*;
  #(parameter int   PAYLOAD_W  = SEQ_PAYLOAD_W,
    parameter int   HDR_W      = 3,
    parameter       HEADER     = SEQ_HEADER,
    parameter       TRAILER    = SEQ_TRAILER,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0)
  (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 data_out,
    output logic                 frame_active,
    output logic                 frame_done
  );

  localparam int                FRAME_LEN = frame_len(HDR_W, PAYLOAD_W);
  localparam int                CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam bit                NO_GAP    = (GAP_CYCLES == 0);

  if ($bits(HEADER) != HDR_W || $bits(TRAILER) != HDR_W) begin : g_width_check
    $error("seq_frame_tx: HEADER and TRAILER must both be HDR_W bits wide");
  end

  tx_state_e             state;
  tx_state_e             state_n;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_n;
  logic                  last_bit;
  logic                  gap_last;
  logic                  accept;
  logic                  load;
  logic                  shift;
  logic                  frame_active_n;
  logic                  frame_done_n;
  logic [FRAME_LEN-1:0]  frame_word;

  assign frame_word = {HEADER, in_payload, TRAILER};
  assign last_bit   = (bit_cnt == LAST_BIT);

  // Ready only depends on registered state so in_valid never loops back into it.
  assign in_ready = !rst && ((state == IDLE) || (NO_GAP && (state == SEND) && last_bit));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      frame_active <= frame_active_n;
      frame_done   <= frame_done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = SEND;
          bit_cnt_n = '0;
        end
      end
      SEND: begin
        if (!last_bit) begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end else if (accept) begin
          bit_cnt_n = '0;
        end else begin
          state_n   = NO_GAP ? IDLE : GAP;
          bit_cnt_n = '0;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
      end
    endcase
  end

  // Flags are computed from the next state so they line up with data_out.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE:    load = accept;
      SEND: begin
        if (!last_bit) begin
          shift = 1'b1;
        end else begin
          load = accept;
        end
      end
      default: begin
        load  = 1'b0;
        shift = 1'b0;
      end
    endcase
    frame_active_n = (state_n == SEND);
    frame_done_n   = (state_n == SEND) && (bit_cnt_n == LAST_BIT);
  end

  if (GAP_CYCLES > 0) begin : g_gap
    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gap_cnt <= '0;
      end else if (state != GAP) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end

    assign gap_last = (gap_cnt == GAP_LAST);
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  seq_piso #(
    .WIDTH    (FRAME_LEN),
    .IDLE_BIT (IDLE_BIT)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (frame_word),
    .shift     (shift),
    .bit_out   (data_out)
  );

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed and soak bench for seq_frame_tx with gap settings of 0, 2 and 3.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] data_out;
  logic [2:0] frame_active;
  logic [2:0] frame_done;
  logic [2:0] in_payload [3];

  int compareCount = 0;
  int failCount    = 0;

  logic [2:0] expMem [3][256];
  int         wrPtr  [3];
  int         rdPtr  [3];

  always #5 clk = ~clk;

  seq_frame_tx #(.GAP_CYCLES(0)) dutGap0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_payload(in_payload[0]), .data_out(data_out[0]),
    .frame_active(frame_active[0]), .frame_done(frame_done[0]));

  seq_frame_tx #(.GAP_CYCLES(2)) dutGap2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_payload(in_payload[1]), .data_out(data_out[1]),
    .frame_active(frame_active[1]), .frame_done(frame_done[1]));

  seq_frame_tx #(.GAP_CYCLES(3)) dutGap3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_payload(in_payload[2]), .data_out(data_out[2]),
    .frame_active(frame_active[2]), .frame_done(frame_done[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkCycle(input int d, input string tag, input logic expData,
                            input logic expActive, input logic expDone, input logic expReady);
    checkOutput($sformatf("%s_data", tag),   32'(data_out[d]),     32'(expData));
    checkOutput($sformatf("%s_active", tag), 32'(frame_active[d]), 32'(expActive));
    checkOutput($sformatf("%s_done", tag),   32'(frame_done[d]),   32'(expDone));
    checkOutput($sformatf("%s_ready", tag),  32'(in_ready[d]),     32'(expReady));
  endtask

  // Offers one payload at a negedge where the DUT is known to be ready.
  task automatic applyStimulus(input int d, input logic [2:0] payload, input bit keepValid);
    @(negedge clk);
    in_payload[d] = payload;
    in_valid[d]   = 1'b1;
    @(posedge clk);
    #1;
    if (!keepValid) in_valid[d] = 1'b0;
  endtask

  task automatic checkFrame(input int d, input string tag, input logic [8:0] frame, input bit lastReady);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkCycle(d, $sformatf("%s_b%0d", tag, i), frame[8-i], 1'b1, (i == 8), lastReady && (i == 8));
    end
  endtask

  task automatic soakProducer(input int d, input int n);
    int sent   = 0;
    int cycles = 0;
    in_valid[d] = 1'b0;
    while (sent < n && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!in_valid[d]) begin
        in_payload[d] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0) in_valid[d] = 1'b1;
      end
      if (in_valid[d] && in_ready[d]) begin
        expMem[d][wrPtr[d]] = in_payload[d];
        wrPtr[d]++;
        sent++;
        @(posedge clk);
        #1;
        if (sent < n && $urandom_range(0, 3) != 0) in_payload[d] = 3'($urandom_range(0, 7));
        else in_valid[d] = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    checkOutput($sformatf("soak%0d_sent", d), 32'(sent), 32'(n));
  endtask

  task automatic soakMonitor(input int d, input int n);
    int         done   = 0;
    int         cycles = 0;
    int         bitCnt = 0;
    logic [8:0] bits   = '0;
    while (done < n && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (frame_active[d]) begin
        bits = {bits[7:0], data_out[d]};
        bitCnt++;
      end
      if (frame_done[d]) begin
        checkOutput($sformatf("soak%0d_len%0d", d, done), 32'(bitCnt), 32'd9);
        checkOutput($sformatf("soak%0d_frame%0d", d, done), 32'(bits),
                    32'({3'b011, expMem[d][rdPtr[d]], 3'b110}));
        rdPtr[d]++;
        done++;
        bitCnt = 0;
      end
    end
    checkOutput($sformatf("soak%0d_done_count", d), 32'(done), 32'(wrPtr[d]));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      in_payload[k] = 3'b000;
      wrPtr[k]      = 0;
      rdPtr[k]      = 0;
    end

    // Reset state
    #1;
    checkOutput("reset_ready",  32'(in_ready),     32'd0);
    checkOutput("reset_data",   32'(data_out),     32'd0);
    checkOutput("reset_active", 32'(frame_active), 32'd0);
    checkOutput("reset_done",   32'(frame_done),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_ready", 32'(in_ready), 32'h7);

    // Single frame, payload 101
    applyStimulus(0, 3'b101, 1'b0);
    checkFrame(0, "single", 9'b011101110, 1'b1);
    @(negedge clk);
    checkCycle(0, "single_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back 000 then 111, valid held
    begin
      logic [17:0] stream;
      stream = 18'b011000110011111110;
      applyStimulus(0, 3'b000, 1'b1);
      in_payload[0] = 3'b111;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        checkCycle(0, $sformatf("b2b_b%0d", i), stream[17-i], 1'b1,
                   (i == 8) || (i == 17), (i == 8) || (i == 17));
        if (i == 8) begin
          @(posedge clk);
          #1;
          in_valid[0] = 1'b0;
        end
      end
      @(negedge clk);
      checkCycle(0, "b2b_after", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Gap of two cycles between queued frames
    applyStimulus(1, 3'b101, 1'b1);
    in_payload[1] = 3'b010;
    checkFrame(1, "gap_f1", 9'b011101110, 1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checkCycle(1, $sformatf("gap1_c%0d", g), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    checkCycle(1, "gap1_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    checkFrame(1, "gap_f2", 9'b011010110, 1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checkCycle(1, $sformatf("gap2_c%0d", g), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    checkCycle(1, "gap2_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Payload captured at accept; later input changes wait for the next frame
    applyStimulus(0, 3'b010, 1'b0);
    in_payload[0] = 3'b111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkCycle(0, $sformatf("stab_f1_b%0d", i), 9'b011010110 >> (8 - i), 1'b1, (i == 8), (i == 8));
      in_valid[0] = (i >= 7) ? 1'b1 : 1'(i % 2);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    checkFrame(0, "stab_f2", 9'b011111110, 1'b1);
    @(negedge clk);
    checkCycle(0, "stab_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame
    applyStimulus(0, 3'b111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkCycle(0, $sformatf("prerst_b%0d", i), 9'b011111110 >> (8 - i), 1'b1, 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    checkCycle(0, "async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("async_rst_ready_all", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkCycle(0, "rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(in_ready[0]), 32'd1);
    applyStimulus(0, 3'b001, 1'b0);
    checkFrame(0, "post_rst", 9'b011001110, 1'b1);
    @(negedge clk);
    checkCycle(0, "post_rst_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Random soak on the zero-gap and three-cycle-gap transmitters
    fork
      soakProducer(0, 100);
      soakMonitor(0, 100);
      soakProducer(2, 100);
      soakMonitor(2, 100);
    join
    repeat (15) @(negedge clk);
    checkOutput("soak_quiet_active", 32'(frame_active), 32'd0);
    checkOutput("soak0_drain", 32'(rdPtr[0]), 32'(wrPtr[0]));
    checkOutput("soak2_drain", 32'(rdPtr[2]), 32'(wrPtr[2]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
